pencere_uretici: RTL and testbench

- Builds 3x3 pixel windows from a raster-order 8-bit pixel stream and feeds the 72-bit window to the median stage (medyan_top.resim_i / etkin_i).
- Holds two line buffers plus a 3x3 shift-register window.
- Emits one window per accepted pixel once two full rows and two columns have been received (valid-region only, no border padding).
- Sits between the pixel source and the median filter.

---
 rtl/pencere_uretici.sv | 143 ++++++++++++++
 tb/tb_pencere_uretici.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pencere_uretici.sv
// Builds 3x3 windows from a raster pixel stream using two line buffers (valid region only).
// Optional end-of-frame flag output enabled by defining PENCERE_CERCEVE_SONU_EN.
`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif

module pencere_uretici #(
    parameter int unsigned GENISLIK  = 320,
    parameter int unsigned YUKSEKLIK = 240
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      etkin_i,
    input  logic [`PIXEL_BIT-1:0]     pixel_i,
    input  logic                      cerceve_baslat_i,
    output logic                      etkin_o,
    output logic [9*`PIXEL_BIT-1:0]   pencere_o
`ifdef PENCERE_CERCEVE_SONU_EN
    ,
    output logic                      cerceve_sonu_o
`endif
);

    localparam int unsigned PB = `PIXEL_BIT;
    localparam int unsigned SW = $clog2(GENISLIK);
    localparam int unsigned HW = $clog2(YUKSEKLIK);
    localparam logic [SW-1:0] SUTUN_SON = SW'(GENISLIK - 1);
    localparam logic [HW-1:0] SATIR_SON = HW'(YUKSEKLIK - 1);

    typedef enum logic [0:0] {StDoldur, StAkis} durum_e;

    durum_e          durum_q, durum_d;
    logic [SW-1:0]   sutun_q, sutun_d, adres;
    logic [HW-1:0]   satir_q, satir_d;
    logic [PB-1:0]   tampon0_q [GENISLIK];
    logic [PB-1:0]   tampon1_q [GENISLIK];
    logic [PB-1:0]   ust, orta;
    logic [PB-1:0]   ust_q [2];
    logic [PB-1:0]   orta_q [2];
    logic [PB-1:0]   alt_q [2];
    logic [9*PB-1:0] pencere_d;
    logic            pencere_gecerli;
    logic            sonu_gecerli;

    // A restart accompanied by a pixel makes that pixel column 0 of the new frame.
    assign adres = cerceve_baslat_i ? '0 : sutun_q;
    assign ust   = tampon1_q[adres];
    assign orta  = tampon0_q[adres];

    // Index [0] is column c-2, [1] is column c-1 relative to the incoming pixel.
    assign pencere_d = {pixel_i, alt_q[1], alt_q[0],
                        orta, orta_q[1], orta_q[0],
                        ust, ust_q[1], ust_q[0]};

    always_comb begin
        sutun_d = sutun_q;
        satir_d = satir_q;
        if (cerceve_baslat_i) begin
            sutun_d = etkin_i ? SW'(1) : '0;
            satir_d = '0;
        end else if (etkin_i) begin
            if (sutun_q == SUTUN_SON) begin
                sutun_d = '0;
                satir_d = (satir_q == SATIR_SON) ? '0 : satir_q + 1'b1;
            end else begin
                sutun_d = sutun_q + 1'b1;
            end
        end
    end

    always_comb begin
        durum_d = (satir_d >= HW'(2)) ? StAkis : StDoldur;
    end

    always_comb begin
        pencere_gecerli = etkin_i && !cerceve_baslat_i && (durum_q == StAkis)
                          && (sutun_q >= SW'(2));
        sonu_gecerli    = pencere_gecerli && (sutun_q == SUTUN_SON) && (satir_q == SATIR_SON);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q <= StDoldur;
            sutun_q <= '0;
            satir_q <= '0;
        end else begin
            durum_q <= durum_d;
            sutun_q <= sutun_d;
            satir_q <= satir_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2; i++) begin
                ust_q[i]  <= '0;
                orta_q[i] <= '0;
                alt_q[i]  <= '0;
            end
        end else if (etkin_i) begin
            ust_q[0]  <= ust_q[1];
            ust_q[1]  <= ust;
            orta_q[0] <= orta_q[1];
            orta_q[1] <= orta;
            alt_q[0]  <= alt_q[1];
            alt_q[1]  <= pixel_i;
        end
    end

    // Line buffers are deliberately unreset; the valid-region rule masks stale data.
    always_ff @(posedge clk_i) begin
        if (etkin_i) begin
            tampon1_q[adres] <= orta;
            tampon0_q[adres] <= pixel_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            etkin_o   <= 1'b0;
            pencere_o <= '0;
        end else begin
            etkin_o <= pencere_gecerli;
            if (pencere_gecerli) begin
                pencere_o <= pencere_d;
            end
        end
    end

`ifdef PENCERE_CERCEVE_SONU_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cerceve_sonu_o <= 1'b0;
        end else begin
            cerceve_sonu_o <= sonu_gecerli;
        end
    end
`else
    logic unused_sonu;
    assign unused_sonu = sonu_gecerli;
`endif

endmodule

// File: tb/tb_pencere_uretici.sv
// Self-checking bench for pencere_uretici: a frame-image reference model builds expected
// windows from the pixels of the current frame.
module tb_pencere_uretici;

    localparam int W = 5;
    localparam int H = 4;
    localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] LAST_WIN  = 72'h34_33_32_24_23_22_14_13_12;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        etkin_i = 1'b0;
    logic [7:0]  pixel_i = '0;
    logic        cerceve_baslat_i = 1'b0;
    logic        etkin_o;
    logic [71:0] pencere_o;
`ifdef PENCERE_CERCEVE_SONU_EN
    logic        cerceve_sonu_o;
`endif

    pencere_uretici #(
        .GENISLIK  (W),
        .YUKSEKLIK (H)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .etkin_i          (etkin_i),
        .pixel_i          (pixel_i),
        .cerceve_baslat_i (cerceve_baslat_i),
        .etkin_o          (etkin_o),
        .pencere_o        (pencere_o)
`ifdef PENCERE_CERCEVE_SONU_EN
        ,
        .cerceve_sonu_o   (cerceve_sonu_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Reference model: image of the current frame plus raster index of the next pixel.
    logic [7:0]  img [H][W];
    int          n_pos;
    logic [71:0] last_win;
    int          pulses;
    int          ends;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_sonu(input logic exp);
`ifdef PENCERE_CERCEVE_SONU_EN
        chk("cerceve_sonu", {71'd0, cerceve_sonu_o}, {71'd0, exp});
        if (cerceve_sonu_o) ends++;
`else
        if (exp) ends++;
`endif
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            etkin_i = 1'b0;
            @(posedge clk_i); #1;
            chk("idle_etkin", {71'd0, etkin_o}, 72'd0);
            chk("idle_hold", pencere_o, last_win);
            chk_sonu(1'b0);
        end
    endtask

    task automatic px(input logic [7:0] v, input logic restart, input int gap);
        int  r, c;
        logic exp_v, exp_s;
        if (restart) n_pos = 0;
        r = n_pos / W;
        c = n_pos % W;
        img[r][c] = v;
        exp_v = (r >= 2) && (c >= 2);
        exp_s = exp_v && (r == H - 1) && (c == W - 1);
        if (exp_v) begin
            for (int k = 0; k < 9; k++) last_win[8*k +: 8] = img[r - 2 + k / 3][c - 2 + k % 3];
        end
        n_pos = (n_pos + 1) % (W * H);
        etkin_i = 1'b1;
        pixel_i = v;
        cerceve_baslat_i = restart;
        @(posedge clk_i); #1;
        etkin_i = 1'b0;
        cerceve_baslat_i = 1'b0;
        chk("etkin", {71'd0, etkin_o}, {71'd0, exp_v});
        chk("pencere", pencere_o, last_win);
        chk_sonu(exp_s);
        if (etkin_o) pulses++;
        idle(gap);
    endtask

    // mode 0: pattern 16r+c, mode 1: random pixels; gap < 0 means random gaps 0..2
    task automatic frame(input int mode, input int gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] v;
            v = (mode == 0) ? 8'(16 * (i / W) + (i % W)) : 8'($urandom);
            px(v, 1'b0, (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        end
    endtask

    task automatic restart_only();
        etkin_i = 1'b0;
        cerceve_baslat_i = 1'b1;
        @(posedge clk_i); #1;
        cerceve_baslat_i = 1'b0;
        n_pos = 0;
        chk("restart_etkin", {71'd0, etkin_o}, 72'd0);
        chk("restart_hold", pencere_o, last_win);
        chk_sonu(1'b0);
    endtask

    task automatic async_reset();
        #3 rstn_i = 1'b0;
        #1;
        n_pos = 0;
        last_win = '0;
        chk("areset_etkin", {71'd0, etkin_o}, 72'd0);
        chk("areset_pencere", pencere_o, 72'd0);
        chk_sonu(1'b0);
        @(posedge clk_i); #3;
        rstn_i = 1'b1;
    endtask

    task automatic count_chk(input string tag, input int exp_pulses, input int exp_ends);
        chk(tag, 72'(pulses), 72'(exp_pulses));
        chk({tag, "_end"}, 72'(ends), 72'(exp_ends));
        pulses = 0;
        ends = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_assert = 0;
        n_fail = 0;
        n_pos = 0;
        pulses = 0;
        ends = 0;
        last_win = '0;

        // Reset state
        #2;
        chk("reset_etkin", {71'd0, etkin_o}, 72'd0);
        chk("reset_pencere", pencere_o, 72'd0);
        chk_sonu(1'b0);
        #21 rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Full-rate frame with explicit boundary windows
        for (int i = 0; i < W * H; i++) begin
            px(8'(16 * (i / W) + (i % W)), 1'b0, 0);
            if (i == 2 * W + 2) chk("first_window", pencere_o, FIRST_WIN);
            if (i == W * H - 1) chk("last_window", pencere_o, LAST_WIN);
        end
        count_chk("full_rate_count", 6, 1);

        // Gapped frame
        frame(0, 2, W * H);
        chk("gapped_last", pencere_o, LAST_WIN);
        count_chk("gapped_count", 6, 1);

        // Back-to-back frames
        frame(0, 0, W * H);
        frame(0, 0, W * H);
        count_chk("b2b_count", 12, 2);

        // Restart after pixel (2,3), then a full frame
        frame(0, 0, 2 * W + 4);
        pulses = 0;
        restart_only();
        idle(2);
        frame(0, 0, W * H);
        count_chk("restart_count", 6, 1);

        // Restart together with a pixel: that pixel is (0,0)
        frame(1, 0, 3 * W + 3);
        pulses = 0;
        px(8'($urandom), 1'b1, 0);
        frame(1, 0, W * H - 1);
        count_chk("restart_px_count", 6, 1);

        // Asynchronous reset mid-row 3
        frame(0, 0, 3 * W + 2);
        pulses = 0;
        async_reset();
        frame(0, 0, W * H);
        count_chk("areset_count", 6, 1);

        // Random pixels with random gaps
        for (int f = 0; f < 4; f++) frame(1, -1, W * H);
        count_chk("random_count", 24, 4);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
